// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : wb_queue
//  Purpose  : In-order write-back queue that sits directly in front of the
//             register-file write port. Requests are accepted by a
//             valid/ready handshake. Requests that target register 0 are
//             accepted but dropped. The head entry is presented on the write
//             port and is popped on every edge. Pending entries are snooped
//             against the two read ports to flag read-after-write hazards.
//  Ports    : clock            - sole clock, rising edge
//             ctrl_reset       - asynchronous active-low reset
//             in_valid/ready   - request handshake
//             in_reg/in_data   - request register index / data
//             ctrl_writeEnable - register-file write strobe (queue not empty)
//             ctrl_writeReg    - head entry register index (0 when empty)
//             data_writeReg    - head entry data (0 when empty)
//             ctrl_readRegA/B  - register-file read indices being snooped
//             hazardA/B        - a queued write targets readRegA/B
//             count            - number of valid entries
//  Revision : 1.0 - initial release
// ============================================================================
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       ctrl_reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_reg,
  input  logic [31:0]                in_data,
  output logic                       ctrl_writeEnable,
  output logic [4:0]                 ctrl_writeReg,
  output logic [31:0]                data_writeReg,
  input  logic [4:0]                 ctrl_readRegA,
  input  logic [4:0]                 ctrl_readRegB,
  output logic                       hazardA,
  output logic                       hazardB,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int              c_PTR_W = $clog2(DEPTH);
  localparam int              c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [4:0]          reg_q  [DEPTH];
  logic [31:0]         data_q [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]  count_q, count_d;

  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_hazard_a;
  logic w_hazard_b;

  // Ready depends on state only, never on in_valid.
  assign in_ready = (count_q != c_FULL);
  assign w_accept = in_valid & in_ready;
  // Register 0 is hard-wired: the handshake completes but nothing is stored.
  assign w_push   = w_accept & (in_reg != 5'd0);
  // The register file always takes the head entry.
  assign w_pop    = (count_q != '0);

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + c_PTR_W'(1);
    end
    if (w_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + c_PTR_W'(1);
    end
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (w_push) begin
        reg_q[wr_ptr_q]  <= in_reg;
        data_q[wr_ptr_q] <= in_data;
      end
    end
  end

  // Stale storage survives a pop, so the write port is gated by occupancy.
  assign ctrl_writeEnable = w_pop;
  assign ctrl_writeReg    = w_pop ? reg_q[rd_ptr_q]  : 5'd0;
  assign data_writeReg    = w_pop ? data_q[rd_ptr_q] : 32'd0;
  assign count            = count_q;

  // Hazard snoop across every valid entry, head included.
  always_comb begin
    w_hazard_a = 1'b0;
    w_hazard_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (reg_q[i] == ctrl_readRegA)) w_hazard_a = 1'b1;
      if (valid_q[i] && (reg_q[i] == ctrl_readRegB)) w_hazard_b = 1'b1;
    end
  end

  assign hazardA = w_hazard_a & (ctrl_readRegA != 5'd0);
  assign hazardB = w_hazard_b & (ctrl_readRegB != 5'd0);

endmodule
`default_nettype wire
